decode: RTL and testbench



---
 rtl/decode.sv | 202 ++++++++++++++++++++
 tb/tb_decode.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// rtl/decode.sv - operand-decode stage: register-file read addressing, immediate expansion, barrel shifter, branch offset
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] insn,
    input  logic [31:0] inpc,
    input  logic [31:0] incpsr,
    input  logic [31:0] inspsr,
    output logic [3:0]  read_0,
    output logic [3:0]  read_1,
    output logic [3:0]  read_2,
    input  logic [31:0] rdata_0,
    input  logic [31:0] rdata_1,
    input  logic [31:0] rdata_2,
    output logic [31:0] op0,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic        carry,
    output logic [31:0] outspsr
);

    typedef enum logic [2:0] {CL_MUL, CL_DPI, CL_DPR, CL_MEM, CL_BLK, CL_BR, CL_NONE} cls_t;

    // Shifter helpers return {carry_out, value}
    function automatic logic [32:0] sh_lsl(input logic [31:0] v, input logic [5:0] n);
        logic [32:0] t;
        t = {1'b0, v} << n;
        return t;
    endfunction

    function automatic logic [32:0] sh_lsr(input logic [31:0] v, input logic [5:0] n);
        logic [32:0] t;
        t = {v, 1'b0} >> n;
        return {t[0], t[32:1]};
    endfunction

    function automatic logic [32:0] sh_asr(input logic [31:0] v, input logic [5:0] n);
        logic [32:0] t;
        t = $signed({v, 1'b0}) >>> n;
        return {t[0], t[32:1]};
    endfunction

    function automatic logic [32:0] sh_ror(input logic [31:0] v, input logic [4:0] n);
        logic [31:0] r;
        r = (v >> n) | (v << (6'd32 - {1'b0, n}));
        return {r[31], r};
    endfunction

    // Immediate amount 0 encodes LSR/ASR #32 and RRX
    function automatic logic [32:0] shift_imm(input logic [31:0] v, input logic [1:0] typ,
                                              input logic [4:0] amt, input logic c);
        logic [32:0] res;
        case (typ)
            2'b00:   res = (amt == 5'd0) ? {c, v} : sh_lsl(v, {1'b0, amt});
            2'b01:   res = sh_lsr(v, (amt == 5'd0) ? 6'd32 : {1'b0, amt});
            2'b10:   res = sh_asr(v, (amt == 5'd0) ? 6'd32 : {1'b0, amt});
            default: res = (amt == 5'd0) ? {v[0], c, v[31:1]} : sh_ror(v, amt);
        endcase
        return res;
    endfunction

    function automatic logic [32:0] shift_reg(input logic [31:0] v, input logic [1:0] typ,
                                              input logic [7:0] amt, input logic c);
        logic [32:0] res;
        if (amt == 8'd0) begin
            res = {c, v};
        end else begin
            case (typ)
                2'b00:   res = (amt > 8'd32) ? 33'd0 : sh_lsl(v, amt[5:0]);
                2'b01:   res = (amt > 8'd32) ? 33'd0 : sh_lsr(v, amt[5:0]);
                2'b10:   res = sh_asr(v, (amt > 8'd32) ? 6'd32 : amt[5:0]);
                default: res = (amt[4:0] == 5'd0) ? {v[31], v} : sh_ror(v, amt[4:0]);
            endcase
        end
        return res;
    endfunction

    cls_t        cls;
    logic        c_in;
    logic [31:0] pc8;
    logic [31:0] val_0;
    logic [31:0] val_1;
    logic [31:0] val_2;
    logic [32:0] sh_res;
    logic [32:0] imm_res;
    logic [31:0] nx_op0;
    logic [31:0] nx_op1;
    logic [31:0] nx_op2;
    logic        nx_carry;

    assign c_in = incpsr[29];
    assign pc8  = inpc + 32'd8;

    always_comb begin
        cls = CL_NONE;
        if (insn[27:22] == 6'd0 && insn[7:4] == 4'b1001) cls = CL_MUL;
        else if (insn[27:25] == 3'b001)                  cls = CL_DPI;
        else if (insn[27:25] == 3'b000)                  cls = CL_DPR;
        else if (insn[27:26] == 2'b01)                   cls = CL_MEM;
        else if (insn[27:25] == 3'b100)                  cls = CL_BLK;
        else if (insn[27:25] == 3'b101)                  cls = CL_BR;
    end

    always_comb begin
        read_0 = 4'd0;
        read_1 = 4'd0;
        read_2 = 4'd0;
        case (cls)
            CL_MUL: begin
                read_0 = insn[15:12];
                read_1 = insn[3:0];
                read_2 = insn[11:8];
            end
            CL_DPI, CL_DPR: begin
                read_0 = insn[19:16];
                read_1 = insn[3:0];
                read_2 = insn[11:8];
            end
            CL_MEM: begin
                read_0 = insn[19:16];
                read_1 = insn[3:0];
                read_2 = insn[15:12];
            end
            CL_BLK:  read_0 = insn[19:16];
            default: ;
        endcase
    end

    // R15 reads see the pipelined PC, including as a shift amount
    assign val_0 = (read_0 == 4'd15) ? pc8 : rdata_0;
    assign val_1 = (read_1 == 4'd15) ? pc8 : rdata_1;
    assign val_2 = (read_2 == 4'd15) ? pc8 : rdata_2;

    always_comb begin
        sh_res  = (insn[4] && cls != CL_MEM) ? shift_reg(val_1, insn[6:5], val_2[7:0], c_in)
                                             : shift_imm(val_1, insn[6:5], insn[11:7], c_in);
        imm_res = (insn[11:8] == 4'd0) ? {c_in, 24'd0, insn[7:0]}
                                       : sh_ror({24'd0, insn[7:0]}, {insn[11:8], 1'b0});
    end

    always_comb begin
        nx_op0   = 32'd0;
        nx_op1   = 32'd0;
        nx_op2   = 32'd0;
        nx_carry = c_in;
        case (cls)
            CL_MUL: begin
                nx_op0 = val_0;
                nx_op1 = val_1;
                nx_op2 = val_2;
            end
            CL_DPI: begin
                nx_op0   = val_0;
                nx_op1   = imm_res[31:0];
                nx_op2   = val_2;
                nx_carry = imm_res[32];
            end
            CL_DPR: begin
                nx_op0   = val_0;
                nx_op1   = sh_res[31:0];
                nx_op2   = val_2;
                nx_carry = sh_res[32];
            end
            CL_MEM: begin
                nx_op0 = val_0;
                nx_op2 = val_2;
                if (insn[25]) begin
                    nx_op1   = sh_res[31:0];
                    nx_carry = sh_res[32];
                end else begin
                    nx_op1 = {20'd0, insn[11:0]};
                end
            end
            CL_BLK: begin
                nx_op0 = val_0;
                nx_op1 = {16'd0, insn[15:0]};
            end
            CL_BR: begin
                nx_op0 = pc8;
                nx_op1 = {{6{insn[23]}}, insn[23:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op0     <= 32'd0;
            op1     <= 32'd0;
            op2     <= 32'd0;
            carry   <= 1'b0;
            outspsr <= 32'd0;
        end else begin
            op0     <= nx_op0;
            op1     <= nx_op1;
            op2     <= nx_op2;
            carry   <= nx_carry;
            outspsr <= inspsr;
        end
    end

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - table-driven, scoreboarded bench for decode
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] insn, inpc, incpsr, inspsr;
    logic [3:0]  read_0, read_1, read_2;
    logic [31:0] rdata_0, rdata_1, rdata_2;
    logic [31:0] op0, op1, op2, outspsr;
    logic        carry;

    decode dut (
        .clk(clk), .rst(rst), .insn(insn), .inpc(inpc), .incpsr(incpsr), .inspsr(inspsr),
        .read_0(read_0), .read_1(read_1), .read_2(read_2),
        .rdata_0(rdata_0), .rdata_1(rdata_1), .rdata_2(rdata_2),
        .op0(op0), .op1(op1), .op2(op2), .carry(carry), .outspsr(outspsr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn, pc, cpsr, d0, d1, d2;
        logic [3:0]  r0, r1, r2;
        logic [31:0] o0, o1, o2;
        logic        c;
    } vec_t;

    typedef struct {
        logic [31:0] o0, o1, o2, spsr;
        logic        c;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic [31:0] i, pc, cpsr, d0, d1, d2,
                                input logic [3:0] r0, r1, r2,
                                input logic [31:0] o0, o1, o2, input logic c);
        vec_t v;
        v.insn = i; v.pc = pc; v.cpsr = cpsr; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.o0 = o0; v.o1 = o1; v.o2 = o2; v.c = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".op0"}, op0, e.o0);
            chk({tag, ".op1"}, op1, e.o1);
            chk({tag, ".op2"}, op2, e.o2);
            chk({tag, ".carry"}, {31'd0, carry}, {31'd0, e.c});
            chk({tag, ".outspsr"}, outspsr, e.spsr);
        end
    endtask

    task automatic drive(input vec_t v, input logic [31:0] spsr);
        insn = v.insn; inpc = v.pc; incpsr = v.cpsr; inspsr = spsr;
        rdata_0 = v.d0; rdata_1 = v.d1; rdata_2 = v.d2;
    endtask

    initial begin
        exp_t z;
        exp_t e;
        vec_t v;
        string tag;
        logic [31:0] spsr;
        z.o0 = 0; z.o1 = 0; z.o2 = 0; z.spsr = 0; z.c = 0;

        // insn, pc, cpsr, rdata0..2, read0..2, op0, op1, op2, carry
        vecs.push_back(mk(32'hE3A004FF, 0, 0, 32'h11111111, 32'h22222222, 32'h33333333,
                          0, 15, 4, 32'h11111111, 32'hFF000000, 32'h33333333, 1));
        vecs.push_back(mk(32'hE0810202, 0, 32'h20000000, 32'hAAAA0000, 32'h0000000F, 5,
                          1, 2, 2, 32'hAAAA0000, 32'h000000F0, 5, 0));
        vecs.push_back(mk(32'hE1A00331, 0, 0, 7, 32'hFFFFFFFF, 33,
                          0, 1, 3, 7, 0, 33, 0));
        vecs.push_back(mk(32'hE1A00331, 0, 0, 7, 32'hFFFFFFFF, 32,
                          0, 1, 3, 7, 0, 32, 1));
        vecs.push_back(mk(32'hE1A00061, 0, 32'h20000000, 9, 2, 4,
                          0, 1, 0, 9, 32'h80000001, 4, 0));
        vecs.push_back(mk(32'hEAFFFFFE, 32'h100, 32'h20000000, 1, 2, 3,
                          0, 0, 0, 32'h108, 32'hFFFFFFF8, 0, 1));
        vecs.push_back(mk(32'hE08F0002, 32'h200, 0, 32'hDEAD0000, 32'h12345678, 9,
                          15, 2, 0, 32'h208, 32'h12345678, 9, 0));
        vecs.push_back(mk(32'hE0214392, 0, 32'h20000000, 32'hA, 32'hB, 32'hC,
                          4, 2, 3, 32'hA, 32'hB, 32'hC, 1));
        vecs.push_back(mk(32'hE5912ABC, 0, 0, 32'h1000, 32'h55, 32'h77,
                          1, 12, 2, 32'h1000, 32'h00000ABC, 32'h77, 0));
        vecs.push_back(mk(32'hE7912103, 0, 0, 32'h2000, 32'hC0000001, 32'h88,
                          1, 3, 2, 32'h2000, 32'h00000004, 32'h88, 1));
        vecs.push_back(mk(32'hE8BD00F0, 0, 32'h20000000, 32'h4000, 32'h5, 32'h6,
                          13, 0, 0, 32'h4000, 32'h000000F0, 0, 1));
        vecs.push_back(mk(32'hEE000000, 0, 32'h20000000, 1, 2, 3,
                          0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(32'hE1A00041, 0, 0, 3, 32'h80000000, 4,
                          0, 1, 0, 3, 32'hFFFFFFFF, 4, 1));
        vecs.push_back(mk(32'hE1A00371, 0, 0, 3, 32'h80000001, 32'h20,
                          0, 1, 3, 3, 32'h80000001, 32'h20, 1));
        vecs.push_back(mk(32'hE1A00331, 0, 32'h20000000, 3, 32'hDEADBEEF, 32'h100,
                          0, 1, 3, 3, 32'hDEADBEEF, 32'h100, 1));
        vecs.push_back(mk(32'hE1A00311, 0, 0, 3, 32'h00000001, 32'h20,
                          0, 1, 3, 3, 0, 32'h20, 1));

        // Reset with garbage registered inputs
        rst = 1'b1;
        drive(vecs[0], 32'hFFFFFFFF);
        sb.push_back(z);
        @(posedge clk); #1;
        pop_check("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            spsr = 32'hC0DE0000 | i;
            tag = $sformatf("v%0d", i);
            drive(v, spsr);
            #1;
            chk({tag, ".read_0"}, {28'd0, read_0}, {28'd0, v.r0});
            chk({tag, ".read_1"}, {28'd0, read_1}, {28'd0, v.r1});
            chk({tag, ".read_2"}, {28'd0, read_2}, {28'd0, v.r2});
            e.o0 = v.o0; e.o1 = v.o1; e.o2 = v.o2; e.c = v.c; e.spsr = spsr;
            sb.push_back(e);
            @(posedge clk); #1;
            pop_check(tag);
        end

        // Reset mid-stream: registers clear but read ports remain live
        v = vecs[1];
        drive(v, 32'h12345678);
        rst = 1'b1;
        #1;
        chk("rst_mid.read_0", {28'd0, read_0}, 32'd1);
        sb.push_back(z);
        @(posedge clk); #1;
        pop_check("rst_mid");
        rst = 1'b0;

        // Recovery: the same instruction loads normally on the following edge
        e.o0 = v.o0; e.o1 = v.o1; e.o2 = v.o2; e.c = v.c; e.spsr = 32'h12345678;
        sb.push_back(e);
        @(posedge clk); #1;
        pop_check("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
